tm_program_loader: RTL
======================

// Module: tm_program_loader
// PURPOSE
//   Drives the Turing machine's user-side interface (input_data/Next/Done) in place of the push buttons.
//   Replays a buffered word list as one Next press per word, then issues a Done pulse.
//   Then issues Next step presses until the machine asserts Compute_done or the step budget runs out.
//   Sits between a host/test fixture (buffer fill + start) and the TuringMachine top.
// PARAMETERS
//   DW        4    width of each tape/program word (matches TuringMachine dw)
//   DEPTH     64   word buffer depth (matches TuringMachine w)
//   AW        $clog2(DEPTH)  buffer address width
//   HOLD      2    cycles Next (or Done) is held high per press, >=1
//   GAP       2    cycles Next/Done held low between presses, >=1
//   MAX_STEPS 255  step-press budget in the RUN phase before timeout
// PORTS
//   clock         in   1       single clock, all logic posedge
//   reset         in   1       synchronous, active-low; clears all state and outputs
//   wr_en         in   1       write wr_data into buffer[wr_addr]; ignored while busy
//   wr_addr       in   AW      buffer write address
//   wr_data       in   DW      buffer write data
//   len           in   AW+1    number of words to send (0..DEPTH); sampled on start
//   start         in   1       1-cycle request to begin; ignored while busy
//   Compute_done  in   1       from TuringMachine; machine reached STOP
//   input_data    out  DW      word presented to TuringMachine
//   Next          out  1       emulated Next button
//   Done          out  1       emulated Done button
//   busy          out  1       high from accepted start until FINISH
//   finished      out  1       1-cycle pulse on reaching FINISH (ok or timeout)
//   timeout       out  1       sticky: step budget exhausted; cleared on next start
//   step_count    out  8       step presses issued in current run; saturates at MAX_STEPS
// BEHAVIOUR
//   Reset (reset==0 at posedge): state IDLE; input_data=0, Next=0, Done=0, busy=0, finished=0,
//     timeout=0, step_count=0; buffer contents are not cleared. Reset mid-operation aborts at once;
//     Next/Done drop low on the following edge.
//   States: IDLE, SETUP, LOAD_HI, LOAD_LO, DONE_HI, DONE_LO, STEP_HI, STEP_LO, FINISH.
//   IDLE: start -> SETUP; latch len into len_q, clear word index idx, step_count, timeout; busy=1.
//   SETUP (1 cycle): input_data<=buffer[0]; Next=0. Then LOAD_HI if len_q!=0, else DONE_HI.
//   LOAD_HI: Next=1 for HOLD cycles; input_data stable (= buffer[idx]) the whole time.
//   LOAD_LO: Next=0 for GAP cycles; on entry idx<=idx+1. On the last gap cycle input_data<=buffer[idx]
//     and -> LOAD_HI, or -> DONE_HI when idx==len_q.
//     Result: input_data changes only while Next is low, at least 1 cycle before the next rising edge.
//   DONE_HI: Done=1, Next=0 for HOLD cycles. DONE_LO: Done=0 for GAP cycles -> STEP_HI.
//   STEP_HI: Next=1 for HOLD cycles; step_count increments once on entry.
//   STEP_LO: Next=0 for GAP cycles, then:
//     -> STEP_HI if step_count<MAX_STEPS; otherwise timeout<=1 -> FINISH.
//   Compute_done sampled high in any of DONE_LO, STEP_HI or STEP_LO:
//     -> FINISH next edge, Next forced low; timeout stays 0.
//     Compute_done wins over budget exhaustion in the same cycle.
//   FINISH (1 cycle): finished=1, busy=0 on exit -> IDLE. input_data holds its last value.
//   Next and Done are never high in the same cycle.
//   All outputs are registered (no combinational path from inputs to Next/Done/input_data).
//   Buffer write while idle: synchronous, 1 cycle; a write concurrent with start is accepted
//     (lands before SETUP reads).
//   len>DEPTH: clamped to DEPTH. Buffer read is synchronous; address is registered one cycle ahead.
//   Word presses per run = len_q; Done presses = 1; step presses <= MAX_STEPS.
// STRUCTURE
//   tm_loader_pkg: state enum tm_loader_state_t (logic [3:0]) and localparam STEP_W=8.
//   Sub-module press_timer: loadable down-counter giving a 1-cycle expire pulse,
//     loaded with HOLD-1 or GAP-1 on each state entry.
//   Buffer: DEPTH x DW register array inside this module; single read port, single write port.
// TESTING
//   len=3, buffer={4'h1,4'h2,4'h3}, HOLD=GAP=2, Compute_done after the 2nd step:
//     exactly 3 Next pulses carrying 1,2,3, then 1 Done pulse, then 2 step pulses; step_count=2,
//     finished pulse, timeout=0.
//   len=0, start: no Next in load phase; Done is the first press; step presses then follow.
//   Compute_done held 0, MAX_STEPS=5:
//     5 step pulses, timeout=1, finished pulses once, busy=0, Next=0 afterwards.
//   reset low during 2nd LOAD_HI:
//     next edge Next=0, busy=0; a new start restarts from word 0.
//   start and wr_en asserted while busy: both ignored; buffer and state unaffected.
//     Compute_done and budget exhaustion in the same cycle: timeout=0.
//   Connect to TuringMachine with a program that halts: Compute_done rises; loader finishes with
//     timeout=0, and display_out matches the expected tape.

Source files
------------

// File: rtl/tm_program_loader_pkg.sv
// Shared types for the Turing machine program loader: FSM state encoding,
// step counter width and state classification helpers.
package tm_program_loader_pkg;

    localparam int STEP_W = 8;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SETUP   = 4'd1,
        S_LOAD_HI = 4'd2,
        S_LOAD_LO = 4'd3,
        S_DONE_HI = 4'd4,
        S_DONE_LO = 4'd5,
        S_STEP_HI = 4'd6,
        S_STEP_LO = 4'd7,
        S_FINISH  = 4'd8
    } tm_loader_state_t;

    function automatic logic is_hi_state(input tm_loader_state_t s);
        return (s == S_LOAD_HI) || (s == S_DONE_HI) || (s == S_STEP_HI);
    endfunction

    function automatic logic is_lo_state(input tm_loader_state_t s);
        return (s == S_LOAD_LO) || (s == S_DONE_LO) || (s == S_STEP_LO);
    endfunction

endpackage

// File: rtl/tm_program_loader_if.sv
// Host/fixture side and Turing machine side signals of the program loader.
// master = host or bench driving the loader, slave = the loader itself.
interface tm_program_loader_if
    import tm_program_loader_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 6
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [AW:0]       len;
    logic              start;
    logic              Compute_done;
    logic [DW-1:0]     input_data;
    logic              Next;
    logic              Done;
    logic              busy;
    logic              finished;
    logic              timeout;
    logic [STEP_W-1:0] step_count;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, Compute_done,
        input  input_data, Next, Done, busy, finished, timeout, step_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, Compute_done,
        output input_data, Next, Done, busy, finished, timeout, step_count
    );

endinterface

// File: rtl/tm_program_loader_press_timer.sv
// Loadable down-counter timing one button press or gap; expire is a single
// cycle pulse once the loaded count has elapsed.
module tm_program_loader_press_timer #(
    parameter int TW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expire
);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            cnt_d   = load_val;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign expire = armed_q && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/tm_program_loader.sv
// Replays a buffered word list into the Turing machine as Next presses, then
// presses Done and keeps stepping until Compute_done or the step budget ends.
module tm_program_loader
    import tm_program_loader_pkg::*;
#(
    parameter int DW        = 4,
    parameter int DEPTH     = 64,
    parameter int AW        = $clog2(DEPTH),
    parameter int HOLD      = 2,
    parameter int GAP       = 2,
    parameter int MAX_STEPS = 255
) (
    input  logic               clock,
    input  logic               reset,
    tm_program_loader_if.slave bus
);

    localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

    tm_loader_state_t  state_q, state_d;
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       idx_q, idx_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DW-1:0]     data_q, data_d;
    logic              next_q, next_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;
    logic              tout_q, tout_d;

    logic [DW-1:0]     buffer_q [DEPTH];
    logic [DW-1:0]     rd_data;
    logic [AW:0]       len_clamped;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_expire;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        return (v >= STEP_W'(MAX_STEPS)) ? v : v + 1'b1;
    endfunction

    tm_program_loader_press_timer #(
        .TW (TW)
    ) u_press_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Writes only land while idle; a write in the start cycle is seen by SETUP.
    always_ff @(posedge clock) begin
        if (bus.wr_en && !busy_q) begin
            buffer_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign rd_data     = buffer_q[rd_addr_q];
    assign len_clamped = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        step_d    = step_q;
        data_d    = data_q;
        tout_d    = tout_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_SETUP;
                    len_d     = len_clamped;
                    idx_d     = '0;
                    rd_addr_d = '0;
                    step_d    = '0;
                    tout_d    = 1'b0;
                end
            end
            S_SETUP: begin
                data_d  = rd_data;
                state_d = (len_q != '0) ? S_LOAD_HI : S_DONE_HI;
            end
            S_LOAD_HI: begin
                if (tmr_expire) begin
                    state_d   = S_LOAD_LO;
                    idx_d     = idx_q + 1'b1;
                    rd_addr_d = idx_d[AW-1:0];
                end
            end
            S_LOAD_LO: begin
                // The next word is latched while Next is still low.
                if (tmr_expire) begin
                    if (idx_q == len_q) begin
                        state_d = S_DONE_HI;
                    end else begin
                        data_d  = rd_data;
                        state_d = S_LOAD_HI;
                    end
                end
            end
            S_DONE_HI: begin
                if (tmr_expire) begin
                    state_d = S_DONE_LO;
                end
            end
            S_DONE_LO: begin
                if (bus.Compute_done) begin
                    state_d = S_FINISH;
                end else if (tmr_expire) begin
                    state_d = S_STEP_HI;
                    step_d  = sat_inc(step_q);
                end
            end
            S_STEP_HI: begin
                if (bus.Compute_done) begin
                    state_d = S_FINISH;
                end else if (tmr_expire) begin
                    state_d = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                // Compute_done outranks an exhausted budget in the same cycle.
                if (bus.Compute_done) begin
                    state_d = S_FINISH;
                end else if (tmr_expire) begin
                    if (step_q < STEP_W'(MAX_STEPS)) begin
                        state_d = S_STEP_HI;
                        step_d  = sat_inc(step_q);
                    end else begin
                        state_d = S_FINISH;
                        tout_d  = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        next_d   = (state_d == S_LOAD_HI) || (state_d == S_STEP_HI);
        done_d   = (state_d == S_DONE_HI);
        busy_d   = (state_d != S_IDLE);
        fin_d    = (state_d == S_FINISH);

        tmr_load = (state_d != state_q) && (is_hi_state(state_d) || is_lo_state(state_d));
        tmr_val  = is_hi_state(state_d) ? TW'(HOLD - 1) : TW'(GAP - 1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            step_q    <= '0;
            data_q    <= '0;
            next_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            step_q    <= step_d;
            data_q    <= data_d;
            next_q    <= next_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            tout_q    <= tout_d;
        end
    end

    assign bus.input_data = data_q;
    assign bus.Next       = next_q;
    assign bus.Done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.finished   = fin_q;
    assign bus.timeout    = tout_q;
    assign bus.step_count = step_q;

endmodule
